// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer for async_fifo1: pops FIFO words into a 2-entry head/skid buffer and presents them as a valid/ready stream.
// Optional sequence checker enabled by defining RD_STREAM_SEQ_CHECK_EN.
module async_fifo_rd_stream #(
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                fifo_rempty,
    input  logic [DATASIZE-1:0] fifo_rdata,
    output logic                fifo_rinc,
    input  logic                flush,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    input  logic                m_ready,
    output logic [1:0]          buf_cnt,
    output logic                seq_err
);

    // Handshake: a word transfers on an rclk edge where m_valid && m_ready; while
    // m_valid && !m_ready, m_data and m_valid hold. fifo_rinc never depends on m_ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATASIZE-1:0] head_q;
    logic [DATASIZE-1:0] skid_q;
    logic                pop;
    logic                take;

    assign pop    = fifo_rinc;
    assign take   = m_valid && m_ready;
    assign m_data = head_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (pop) state_d = ST_ONE;
                ST_ONE: begin
                    if (pop && !take)      state_d = ST_FULL;
                    else if (!pop && take) state_d = ST_EMPTY;
                end
                ST_FULL:  if (take) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Popping is also held off during reset so the FIFO is left untouched.
    always_comb begin
        m_valid   = (state_q != ST_EMPTY);
        fifo_rinc = !rrst && !fifo_rempty && !flush && (state_q != ST_FULL);
        buf_cnt   = state_q;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state_q)
                ST_EMPTY: if (pop) head_q <= fifo_rdata;
                ST_ONE: begin
                    if (pop && take) head_q <= fifo_rdata;
                    else if (pop)    skid_q <= fifo_rdata;
                end
                ST_FULL:  if (take) head_q <= skid_q;
                default: ;
            endcase
        end
    end

`ifdef RD_STREAM_SEQ_CHECK_EN
    logic                seq_seeded;
    logic [DATASIZE-1:0] seq_exp;

    // Expected value always re-seeds from the word just taken, so one gap flags once.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            seq_seeded <= 1'b0;
            seq_exp    <= '0;
            seq_err    <= 1'b0;
        end else if (flush) begin
            seq_seeded <= 1'b0;
            seq_err    <= 1'b0;
        end else if (take) begin
            seq_seeded <= 1'b1;
            seq_exp    <= m_data + DATASIZE'(1);
            if (seq_seeded && (m_data != seq_exp)) begin
                seq_err <= 1'b1;
            end
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule
